// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports, NWRITE write ports, per-register busy scoreboard.
// Reads are zero-latency with same-cycle write bypass; writes and scoreboard updates land on the rising edge.
// No backpressure; after reset, ready stays low for NREGS-1 cycles while storage is zeroed one entry per cycle.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*$clog2(NREGS)-1:0]  ra,
    output logic [NREAD*XLEN-1:0]    rd,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*$clog2(NREGS)-1:0] wa,
    input  logic [NWRITE*XLEN-1:0]   wd,
    input  logic                     set_en,
    input  logic [$clog2(NREGS)-1:0] set_addr,
    output logic                     ready
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;
    logic            run;

    // Entry 0 is never written or read; register 0 is synthesised as constant zero.
    logic [XLEN-1:0] rf [NREGS];
    logic [NREGS-1:0] busy;

    // Read-path scratch values, reassigned per port inside the read process.
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rval;
    logic            rbsy;

    assign run   = (state == RUN);
    assign ready = run;

    // State and clear-counter register; reset (re)starts the clear sweep at entry 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: sweep the counter through 1..NREGS-1, then hand over to RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Storage: zeroed one entry per cycle in CLEAR; in RUN ports apply in index order so the highest port wins.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            rf[cnt] <= '0;
        end else if (!reset) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    rf[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard: writes retire a producer, set_en records a new one; the set is applied last so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else if (run) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    busy[wa[j*AW +: AW]] <= 1'b0;
                end
            end
            if (set_en && (set_addr != '0)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    // Read ports: x0 reads zero, in-flight writes bypass storage and mask the busy flag, CLEAR reads all zero.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        raddr = '0;
        rval  = '0;
        rbsy  = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            raddr = ra[i*AW +: AW];
            rval  = '0;
            rbsy  = 1'b0;
            if (run && (raddr != '0)) begin
                rval = rf[raddr];
                rbsy = busy[raddr];
                for (int j = 0; j < NWRITE; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == raddr)) begin
                        rval = wd[j*XLEN +: XLEN];
                        rbsy = 1'b0;
                    end
                end
            end
            rd[i*XLEN +: XLEN] = rval;
            rbusy[i]           = rbsy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp in a dual-read, dual-write configuration.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after that.
// Each scenario task carries its own expected values.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clk;
    logic                   reset;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*XLEN-1:0]  rd;
    logic [NREAD-1:0]       rbusy;
    logic [NWRITE-1:0]      we;
    logic [NWRITE*AW-1:0]   wa;
    logic [NWRITE*XLEN-1:0] wd;
    logic                   set_en;
    logic [AW-1:0]          set_addr;
    logic                   ready;

    int compared;
    int mismatched;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .set_en   (set_en),
        .set_addr (set_addr),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = '0;
        wa       = '0;
        wd       = '0;
        set_en   = 1'b0;
        set_addr = '0;
    endtask

    // Pulses reset for one edge, then counts edges until ready rises (bounded).
    task automatic reset_and_count(output int cycles);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cycles = 0;
        while (!ready && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        idle();
        ra = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        compared++;
        if (ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready_low: got %b want 0", ready);
        end
        ra[0 +: AW] = 5'd3;
        ra[AW +: AW] = 5'd17;
        #1;
        compared++;
        if (rd !== 64'h0 || rbusy !== 2'b00) begin
            mismatched++;
            $display("FAIL clear_reads_zero: rd=%h rbusy=%b want 0/00", rd, rbusy);
        end
        cycles = 0;
        while (!ready && cycles < 100) begin
            step();
            cycles++;
        end
        compared++;
        if (cycles != 31) begin
            mismatched++;
            $display("FAIL clear_length: got %0d cycles want 31", cycles);
        end
        for (int r = 0; r < NREGS; r++) begin
            ra[0 +: AW] = AW'(r);
            ra[AW +: AW] = AW'(NREGS - 1 - r);
            #1;
            compared++;
            if (rd !== 64'h0) begin
                mismatched++;
                $display("FAIL cleared_reg_%0d: rd=%h want 0", r, rd);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 2'b01;
        wa[0 +: AW] = 5'd5;
        wd[0 +: XLEN] = 32'hDEADBEEF;
        step();
        idle();
        ra[0 +: AW] = 5'd5;
        ra[AW +: AW] = 5'd5;
        #1;
        compared++;
        if (rd[0 +: XLEN] !== 32'hDEADBEEF || rd[XLEN +: XLEN] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL write_read_r5: rd=%h want deadbeef on both", rd);
        end
        we = 2'b01;
        wa[0 +: AW] = 5'd0;
        wd[0 +: XLEN] = 32'h12345678;
        ra[0 +: AW] = 5'd0;
        #1;
        compared++;
        if (rd[0 +: XLEN] !== 32'h0) begin
            mismatched++;
            $display("FAIL x0_no_bypass: got %h want 0", rd[0 +: XLEN]);
        end
        step();
        idle();
        #1;
        compared++;
        if (rd[0 +: XLEN] !== 32'h0 || rbusy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL x0_stays_zero: rd=%h rbusy=%b want 0/0", rd[0 +: XLEN], rbusy[0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_en = 1'b1;
        set_addr = 5'd7;
        step();
        idle();
        ra[AW +: AW] = 5'd7;
        #1;
        compared++;
        if (rbusy[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL r7_busy_before: got %b want 1", rbusy[1]);
        end
        we = 2'b01;
        wa[0 +: AW] = 5'd7;
        wd[0 +: XLEN] = 32'hA5A5A5A5;
        #1;
        compared++;
        if (rd[XLEN +: XLEN] !== 32'hA5A5A5A5 || rbusy[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL bypass_r7: rd=%h rbusy=%b want a5a5a5a5/0", rd[XLEN +: XLEN], rbusy[1]);
        end
        step();
        idle();
        #1;
        compared++;
        if (rd[XLEN +: XLEN] !== 32'hA5A5A5A5 || rbusy[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL r7_after_write: rd=%h rbusy=%b want a5a5a5a5/0", rd[XLEN +: XLEN], rbusy[1]);
        end
    endtask

    task automatic test_conflict();
        idle();
        we = 2'b11;
        wa[0 +: AW] = 5'd3;
        wa[AW +: AW] = 5'd3;
        wd[0 +: XLEN] = 32'h11;
        wd[XLEN +: XLEN] = 32'h22;
        ra[0 +: AW] = 5'd3;
        #1;
        compared++;
        if (rd[0 +: XLEN] !== 32'h22) begin
            mismatched++;
            $display("FAIL conflict_bypass: got %h want 22", rd[0 +: XLEN]);
        end
        step();
        idle();
        #1;
        compared++;
        if (rd[0 +: XLEN] !== 32'h22) begin
            mismatched++;
            $display("FAIL conflict_stored: got %h want 22", rd[0 +: XLEN]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        ra[0 +: AW] = 5'd9;
        ra[AW +: AW] = 5'd0;
        set_en = 1'b1;
        set_addr = 5'd9;
        step();
        idle();
        #1;
        compared++;
        if (rbusy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL r9_set: got %b want 1", rbusy[0]);
        end
        we = 2'b10;
        wa[AW +: AW] = 5'd9;
        wd[XLEN +: XLEN] = 32'h0000_0999;
        step();
        idle();
        #1;
        compared++;
        if (rbusy[0] !== 1'b0 || rd[0 +: XLEN] !== 32'h0000_0999) begin
            mismatched++;
            $display("FAIL r9_cleared: rbusy=%b rd=%h want 0/00000999", rbusy[0], rd[0 +: XLEN]);
        end
        we = 2'b01;
        wa[0 +: AW] = 5'd9;
        wd[0 +: XLEN] = 32'h0000_0AAA;
        set_en = 1'b1;
        set_addr = 5'd9;
        step();
        idle();
        #1;
        compared++;
        if (rbusy[0] !== 1'b1 || rd[0 +: XLEN] !== 32'h0000_0AAA) begin
            mismatched++;
            $display("FAIL r9_set_wins: rbusy=%b rd=%h want 1/00000aaa", rbusy[0], rd[0 +: XLEN]);
        end
        set_en = 1'b1;
        set_addr = 5'd0;
        step();
        idle();
        #1;
        compared++;
        if (rbusy[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL x0_never_busy: got %b want 0", rbusy[1]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
        end
        compared++;
        if (ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_clear_ready: got %b want 0", ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        // Ten cycles into the restarted sweep, try a write and a set to r2 (already swept): both must be ignored.
        cycles = 0;
        while (!ready && cycles < 100) begin
            if (cycles == 10) begin
                we = 2'b01;
                wa[0 +: AW] = 5'd2;
                wd[0 +: XLEN] = 32'hBAD0BAD0;
                set_en = 1'b1;
                set_addr = 5'd2;
            end else begin
                idle();
            end
            step();
            cycles++;
        end
        idle();
        compared++;
        if (cycles != 31) begin
            mismatched++;
            $display("FAIL restart_clear_length: got %0d cycles want 31", cycles);
        end
        ra[0 +: AW] = 5'd2;
        ra[AW +: AW] = 5'd5;
        #1;
        compared++;
        if (rd !== 64'h0 || rbusy !== 2'b00) begin
            mismatched++;
            $display("FAIL clear_ignores_we_set: rd=%h rbusy=%b want 0/00", rd, rbusy);
        end
    endtask

    task automatic test_reset_in_run();
        int cycles;
        idle();
        set_en = 1'b1;
        set_addr = 5'd10;
        step();
        set_addr = 5'd11;
        step();
        idle();
        ra[0 +: AW] = 5'd10;
        ra[AW +: AW] = 5'd11;
        #1;
        compared++;
        if (rbusy !== 2'b11) begin
            mismatched++;
            $display("FAIL busy_before_reset: got %b want 11", rbusy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++;
        if (ready !== 1'b0 || rbusy !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_in_run: ready=%b rbusy=%b want 0/00", ready, rbusy);
        end
        cycles = 0;
        while (!ready && cycles < 100) begin
            step();
            cycles++;
        end
        compared++;
        if (cycles != 31 || rbusy !== 2'b00) begin
            mismatched++;
            $display("FAIL busy_after_rerun: cycles=%0d rbusy=%b want 31/00", cycles, rbusy);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        ra         = '0;
        idle();
        step();
        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_reset_mid_clear();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
